// File: rtl/cache_pkg.sv
// Shared types and helpers for the trace front-end: op-byte encodings, feeder
// states, the buffered request record, and the index/tag address split.
package cache_pkg;

  localparam int unsigned ADDR_W = 48;

  localparam logic [7:0] OP_R_U = 8'h52;
  localparam logic [7:0] OP_R_L = 8'h72;
  localparam logic [7:0] OP_W_U = 8'h57;
  localparam logic [7:0] OP_W_L = 8'h77;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} feed_state_t;

  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
  } trace_req_t;

  typedef struct packed {
    logic [31:0] index;
    logic [31:0] tag;
  } addr_split_t;

  function automatic logic op_is_legal(input logic [7:0] op);
    return (op == OP_R_U) || (op == OP_R_L) || (op == OP_W_U) || (op == OP_W_L);
  endfunction

  function automatic logic op_is_write(input logic [7:0] op);
    return (op == OP_W_U) || (op == OP_W_L);
  endfunction

  // Drop the line offset, then split the remaining line address into set index and tag.
  function automatic addr_split_t addr_split(input logic [ADDR_W-1:0] addr,
                                             input int unsigned       off,
                                             input int unsigned       ib);
    logic [ADDR_W-1:0] line;
    logic [ADDR_W-1:0] mask;
    addr_split_t       r;
    line    = addr >> off;
    mask    = (ADDR_W'(1) << ib) - ADDR_W'(1);
    r.index = 32'(line & mask);
    r.tag   = 32'(line >> ib);
    return r;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Small synchronous FIFO for buffered trace records; power-of-2 depth so the
// pointers wrap naturally.
module trace_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cache_trace_feeder.sv
// Trace front-end: validates op bytes, buffers records, splits addresses into
// L1/L2 index/tag and presents them through a single output register slice.
module cache_trace_feeder
  import cache_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = 64,
  parameter int unsigned L1_NUMSETS = 64,
  parameter int unsigned L2_NUMSETS = 512,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_write,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_l1_index,
  output logic [31:0]       out_l1_tag,
  output logic [31:0]       out_l2_index,
  output logic [31:0]       out_l2_tag,
  output logic [CNT_W-1:0]  out_seq,
  output logic [CNT_W-1:0]  rec_count,
  output logic [CNT_W-1:0]  bad_count,
  output logic              done
);

  localparam int unsigned OFF        = $clog2(BLOCK_SIZE);
  localparam int unsigned L1_IB      = $clog2(L1_NUMSETS);
  localparam int unsigned L2_IB      = $clog2(L2_NUMSETS);
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

  feed_state_t           state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  trace_req_t            out_req_q, out_req_d;
  addr_split_t           l1_q, l1_d, l2_q, l2_d;
  logic [CNT_W-1:0]      rec_count_q, rec_count_d;
  logic [CNT_W-1:0]      bad_count_q, bad_count_d;

  trace_req_t            push_req, head;
  logic                  fifo_full, fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  in_fire, legal, push, pop, fire;

  // Gating with reset keeps in_ready low while reset is held, not just after it.
  assign in_ready = reset && ((state_q == IDLE) || (state_q == RUN)) && !fifo_full;
  assign in_fire  = in_valid && in_ready;
  assign legal    = op_is_legal(in_op);
  assign push     = in_fire && legal;
  assign fire     = out_valid_q && out_ready;
  // Slice refills when empty or emptying this cycle: one record per cycle.
  assign pop      = !fifo_empty && (!out_valid_q || out_ready);

  assign push_req.is_write = op_is_write(in_op);
  assign push_req.addr     = in_addr;

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(trace_req_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .wdata (push_req),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_req_d   = out_req_q;
    l1_d        = l1_q;
    l2_d        = l2_q;
    rec_count_d = rec_count_q;
    bad_count_d = bad_count_q;

    unique case (state_q)
      IDLE:    if (in_fire) state_d = in_last ? DRAIN : RUN;
      RUN:     if (in_fire && in_last) state_d = DRAIN;
      DRAIN:   if ((fifo_count == '0) && !out_valid_q) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (pop) begin
      out_valid_d = 1'b1;
      out_req_d   = head;
      l1_d        = addr_split(head.addr, OFF, L1_IB);
      l2_d        = addr_split(head.addr, OFF, L2_IB);
    end else if (fire) begin
      out_valid_d = 1'b0;
    end

    if (fire && (rec_count_q != '1))           rec_count_d = rec_count_q + CNT_W'(1);
    if (in_fire && !legal && (bad_count_q != '1)) bad_count_d = bad_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_req_q   <= '0;
      l1_q        <= '0;
      l2_q        <= '0;
      rec_count_q <= '0;
      bad_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_req_q   <= out_req_d;
      l1_q        <= l1_d;
      l2_q        <= l2_d;
      rec_count_q <= rec_count_d;
      bad_count_q <= bad_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_is_write = out_req_q.is_write;
  assign out_addr     = out_req_q.addr;
  assign out_l1_index = l1_q.index;
  assign out_l1_tag   = l1_q.tag;
  assign out_l2_index = l2_q.index;
  assign out_l2_tag   = l2_q.tag;
  // The presented request's ordinal is the count of requests issued before it.
  assign out_seq      = rec_count_q;
  assign rec_count    = rec_count_q;
  assign bad_count    = bad_count_q;
  assign done         = (state_q == DONE);

endmodule
